qpimem_burst_ctl: RTL and testbench

- Line-burst front end sitting directly upstream of the dual-PSRAM QPI interface (qpimem_iface_intl); driven by the QPI cache controller.
- Turns one cache-line request into a single do_read/do_write burst of LINE_WORDS 32-bit words.
- The QPI interface has no backpressure once a burst starts, so write lines are fully buffered before issue and read lines are captured into the same buffer, then streamed upstream under valid/ready.

---
 rtl/qpimem_pkg.sv | 21 ++
 rtl/qpimem_line_buf.sv | 29 ++
 rtl/qpimem_burst_ctl.sv | 182 ++++++++++++++++++
 tb/tb_qpimem_burst_ctl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpimem_pkg.sv
// Shared definitions for the QPI line-burst front end: FSM state encoding,
// default line length and the counter-width helper.
package qpimem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WFILL  = 3'd1,
    WAITQ  = 3'd2,
    WBURST = 3'd3,
    RBURST = 3'd4,
    RDRAIN = 3'd5
  } state_t;

  localparam int unsigned LINE_WORDS_DEF = 8;

  // Counter must reach LINE_WORDS itself, so one bit wider than the index.
  function automatic int unsigned cnt_w(input int unsigned words);
    return 32'($clog2(words) + 1);
  endfunction

endpackage

// File: rtl/qpimem_line_buf.sv
// Line buffer: WORDS x 32 register array, one synchronous write port and one
// combinational read port. No reset; contents are only meaningful after a fill.
//   clk    clock
//   we     write enable
//   widx   write word index
//   wdata  write word
//   ridx   read word index
//   rdata  read word (combinational)
module qpimem_line_buf #(
  parameter int unsigned WORDS = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/qpimem_burst_ctl.sv
// Line-burst front end for the dual-PSRAM QPI interface. Converts one cache-line
// request into a single do_read/do_write burst of LINE_WORDS words. Write lines
// are fully buffered before issue; read lines are captured into the same buffer
// and then streamed upstream under valid/ready.
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready/write/addr    line request from the cache controller
//   wr_data/valid/ready           writeback words, word 0 first
//   rd_data/valid/ready           fill words, word 0 first
//   q_do_read, q_do_write, q_addr, q_wdata        to QPI interface
//   q_next_word, q_rdata, q_is_idle               from QPI interface
module qpimem_burst_ctl
  import qpimem_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned AW         = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          q_do_read,
  output logic          q_do_write,
  input  logic          q_next_word,
  output logic [AW-1:0] q_addr,
  output logic [31:0]   q_wdata,
  input  logic [31:0]   q_rdata,
  input  logic          q_is_idle
);

  localparam int unsigned CNT_W   = cnt_w(LINE_WORDS);
  localparam int unsigned IDX_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned OFF_W   = $clog2(LINE_WORDS * 4);
  localparam int unsigned RD_STOP = (LINE_WORDS > 2) ? LINE_WORDS - 2 : 0;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(RD_STOP);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              do_read_q, do_read_d;
  logic              is_wr_q, is_wr_d;
  logic              buf_we;
  logic [31:0]       buf_wdata;
  logic [31:0]       buf_rdata;
  logic              unused_addr_lsb;

  // Offset bits inside the line are dropped by design.
  assign unused_addr_lsb = ^req_addr[OFF_W-1:0];

  qpimem_line_buf #(
    .WORDS (LINE_WORDS),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (cnt_q[IDX_W-1:0]),
    .wdata (buf_wdata),
    .ridx  (cnt_q[IDX_W-1:0]),
    .rdata (buf_rdata)
  );

  // State, counter, latched address and the registered do_read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      do_read_q <= 1'b0;
      is_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      do_read_q <= do_read_d;
      is_wr_q   <= is_wr_d;
    end
  end

  // Next-state, counter and buffer-write control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    do_read_d = do_read_q;
    is_wr_d   = is_wr_q;
    buf_we    = 1'b0;
    buf_wdata = q_rdata;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[AW-1:OFF_W], OFF_W'(0)};
          cnt_d   = '0;
          is_wr_d = req_write;
          state_d = req_write ? WFILL : WAITQ;
        end
      end

      WFILL: begin
        if (wr_valid) begin
          buf_we    = 1'b1;
          buf_wdata = wr_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = WAITQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Hold off until the interface has fully closed the previous burst.
      WAITQ: begin
        if (q_is_idle) begin
          state_d   = is_wr_q ? WBURST : RBURST;
          do_read_d = !is_wr_q;
        end
      end

      WBURST: begin
        if (q_next_word) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Words past the line end are interface overrun and are dropped.
      RBURST: begin
        if (cnt_q == CNT_FULL) begin
          if (!do_read_q) begin
            cnt_d   = '0;
            state_d = RDRAIN;
          end
        end else if (q_next_word) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          // Dropping do_read here lets the interface fetch exactly one more word.
          if (cnt_q == CNT_STOP) do_read_d = 1'b0;
        end
      end

      RDRAIN: begin
        if (rd_ready) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WFILL);
  assign rd_valid  = (state_q == RDRAIN);
  assign rd_data   = buf_rdata;
  assign q_wdata   = buf_rdata;
  assign q_addr    = addr_q;
  assign q_do_read = do_read_q;
  // The interface samples do_write in the next_word cycle, so the drop on the
  // last word must be combinational.
  assign q_do_write = (state_q == WBURST) && !(q_next_word && (cnt_q == CNT_LAST));

endmodule

// File: tb/tb_qpimem_burst_ctl.sv
// Self-checking bench for qpimem_burst_ctl with a behavioural QPI interface
// model and a word-level reference memory.
module tb_qpimem_burst_ctl;

  localparam int unsigned LW = 8;
  localparam int unsigned AW = 24;

  logic          clk, rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   wr_data;
  logic          wr_valid, wr_ready;
  logic [31:0]   rd_data;
  logic          rd_valid, rd_ready;
  logic          q_do_read, q_do_write, q_next_word;
  logic [AW-1:0] q_addr;
  logic [31:0]   q_wdata, q_rdata;
  logic          q_is_idle;

  qpimem_burst_ctl #(.LINE_WORDS(LW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .q_do_read(q_do_read), .q_do_write(q_do_write), .q_next_word(q_next_word),
    .q_addr(q_addr), .q_wdata(q_wdata), .q_rdata(q_rdata), .q_is_idle(q_is_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] mem     [1024];  // interface-side memory
  logic [31:0] ref_mem [1024];  // expected memory contents
  logic [31:0] line_w  [LW];
  logic [31:0] rd_got  [LW];
  logic [AW-1:0] acc_q_addr;

  // Interface model state and configuration.
  int m_busy = 0, m_write = 0, m_word = 0, m_gap = 0, m_idle_hold = 0, m_extra = 0, m_base = 0;
  int m_pulses = 0, m_stop_word = -1, m_wr_total = 0, m_start_viol = 0;
  int m_first_pulse_cyc = 0, m_last_pulse_cyc = 0;
  int idle_hold_cfg = 1, inject_extra = 0, pulse_gap_cfg = 0;

  function automatic int line_idx(input logic [AW-1:0] a);
    return int'(a[11:2]) & ~(int'(LW) - 1);
  endfunction

  // Behavioural QPI interface: starts on do_read/do_write while idle, emits one
  // next_word per word, and in each next_word cycle samples do_x to decide
  // whether another word follows. Drives at negedge+2, samples at negedge+3.
  initial begin
    q_next_word = 1'b0;
    q_rdata     = '0;
    q_is_idle   = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      q_next_word = 1'b0;
      if (rst) begin
        m_busy = 0; m_extra = 0; m_idle_hold = 0; q_is_idle = 1'b1;
      end else if (m_extra > 0) begin
        q_next_word = 1'b1;
        q_rdata     = 32'hDEADBEEF;
        m_extra--;
      end else if (m_busy == 0) begin
        if (!q_is_idle && (q_do_read || q_do_write)) m_start_viol++;
        if (m_idle_hold > 0) begin
          m_idle_hold--;
          q_is_idle = (m_idle_hold == 0);
        end else if (q_do_write || q_do_read) begin
          m_busy = 1; m_write = int'(q_do_write); m_word = 0; m_gap = 2;
          q_is_idle = 1'b0; m_base = int'(q_addr[11:2]); m_pulses = 0; m_stop_word = -1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        q_next_word = 1'b1;
        if (m_write != 0) begin
          mem[(m_base + m_word) % 1024] = q_wdata;
          m_wr_total++;
        end else begin
          q_rdata = mem[(m_base + m_word) % 1024];
        end
        if (m_pulses == 0) m_first_pulse_cyc = cyc;
        m_last_pulse_cyc = cyc;
        m_pulses++;
        #1;
        if (!((m_write != 0) ? q_do_write : q_do_read)) begin
          m_busy = 0; m_stop_word = m_word; m_idle_hold = idle_hold_cfg;
          if (m_write == 0) m_extra = inject_extra;
        end else begin
          m_gap = pulse_gap_cfg;
        end
        m_word++;
      end
    end
  end

  // Request handshake; records q_addr one cycle after acceptance.
  task automatic send_req(input logic wr, input logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = AW'($urandom);
    #1;
    acc_q_addr = q_addr;
  endtask

  // Feed line_w, one word offered every 'every' cycles; flags early do_write.
  task automatic fill_words(input int every, output bit ok, output bit early_dw);
    int i = 0;
    early_dw = 1'b0;
    for (int n = 0; n < 1000 && i < int'(LW); n++) begin
      @(negedge clk);
      wr_valid = (n % every == 0);
      wr_data  = line_w[i];
      #1;
      if (q_do_write) early_dw = 1'b1;
      if (wr_valid && wr_ready) i++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    ok = (i == int'(LW));
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
  endtask

  // Collect a fill line. mode 0: always ready, 1: toggle, 2: random.
  task automatic drain(input int mode, output int got, output bit rr_early);
    got = 0;
    rr_early = 1'b0;
    for (int n = 0; n < 1000 && got < int'(LW); n++) begin
      @(negedge clk);
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom);
      #1;
      if (req_ready) rr_early = 1'b1;
      if (rd_valid && rd_ready) begin
        rd_got[got] = rd_data;
        got++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
  endtask

  task automatic write_line(input logic [AW-1:0] a, input int every, output bit ok, output bit early_dw);
    bit ok1, ok2, ok3;
    send_req(1'b1, a, ok1);
    fill_words(every, ok2, early_dw);
    wait_idle(ok3);
    ok = ok1 && ok2 && ok3;
    for (int k = 0; k < int'(LW); k++) ref_mem[line_idx(a) + k] = line_w[k];
  endtask

  task automatic read_line(input logic [AW-1:0] a, input int mode, output bit ok, output int got, output bit rr_early);
    send_req(1'b0, a, ok);
    drain(mode, got, rr_early);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (q_do_read !== 1'b0) begin errors++; $display("FAIL reset_do_read got %b exp 0", q_do_read); end
    checks++; if (q_do_write !== 1'b0) begin errors++; $display("FAIL reset_do_write got %b exp 0", q_do_write); end
    checks++; if (q_addr !== '0) begin errors++; $display("FAIL reset_q_addr got %h exp 0", q_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_basic();
    bit ok1, ok2, ok3, early;
    int wr0 = m_wr_total;
    for (int k = 0; k < int'(LW); k++) line_w[k] = 32'h11111111 * 32'(k + 1);
    send_req(1'b1, 24'h000123, ok1);
    checks++; if (acc_q_addr !== 24'h000120) begin errors++; $display("FAIL wr_q_addr got %h exp 000120", acc_q_addr); end
    fill_words(1, ok2, early);
    wait_idle(ok3);
    for (int k = 0; k < int'(LW); k++) ref_mem[line_idx(24'h000123) + k] = line_w[k];
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL wr_handshake got %b%b%b exp 111", ok1, ok2, ok3); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL wr_early_do_write got %b exp 0", early); end
    checks++; if (m_pulses != int'(LW)) begin errors++; $display("FAIL wr_pulses got %0d exp %0d", m_pulses, LW); end
    checks++; if (m_stop_word != int'(LW) - 1) begin errors++; $display("FAIL wr_drop_word got %0d exp %0d", m_stop_word, LW - 1); end
    checks++; if (m_wr_total - wr0 != int'(LW)) begin errors++; $display("FAIL wr_word_count got %0d exp %0d", m_wr_total - wr0, LW); end
    for (int k = 0; k < int'(LW); k++) begin
      checks++;
      if (mem[line_idx(24'h000120) + k] !== 32'h11111111 * 32'(k + 1)) begin
        errors++; $display("FAIL wr_mem[%0d] got %h exp %h", k, mem[line_idx(24'h000120) + k], 32'h11111111 * 32'(k + 1));
      end
    end
  endtask

  task automatic test_read_basic();
    bit ok, rr;
    int got;
    for (int k = 0; k < int'(LW); k++) begin
      mem[line_idx(24'h000200) + k]     = 32'hA0A0A0A0 + 32'h01010101 * 32'(k);
      ref_mem[line_idx(24'h000200) + k] = 32'hA0A0A0A0 + 32'h01010101 * 32'(k);
    end
    inject_extra = 2;
    read_line(24'h000200, 0, ok, got, rr);
    inject_extra = 0;
    checks++; if (!ok || got != int'(LW)) begin errors++; $display("FAIL rd_count got %0d exp %0d", got, LW); end
    checks++; if (m_pulses != int'(LW)) begin errors++; $display("FAIL rd_pulses got %0d exp %0d", m_pulses, LW); end
    checks++; if (m_stop_word != int'(LW) - 1) begin errors++; $display("FAIL rd_do_read_drop got %0d exp %0d", m_stop_word, LW - 1); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_after got %b exp 0", rd_valid); end
    for (int k = 0; k < int'(LW); k++) begin
      checks++;
      if (rd_got[k] !== 32'hA0A0A0A0 + 32'h01010101 * 32'(k)) begin
        errors++; $display("FAIL rd_word[%0d] got %h exp %h", k, rd_got[k], 32'hA0A0A0A0 + 32'h01010101 * 32'(k));
      end
    end
  endtask

  task automatic test_read_toggle();
    bit ok, rr;
    int got;
    read_line(24'h000120, 1, ok, got, rr);
    checks++; if (!ok || got != int'(LW)) begin errors++; $display("FAIL tog_count got %0d exp %0d", got, LW); end
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL tog_req_ready_early got %b exp 0", rr); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL tog_req_ready_after got %b exp 1", req_ready); end
    for (int k = 0; k < int'(LW); k++) begin
      checks++;
      if (rd_got[k] !== ref_mem[line_idx(24'h000120) + k]) begin
        errors++; $display("FAIL tog_word[%0d] got %h exp %h", k, rd_got[k], ref_mem[line_idx(24'h000120) + k]);
      end
    end
  endtask

  task automatic test_write_gaps();
    bit ok, early;
    for (int k = 0; k < int'(LW); k++) line_w[k] = $urandom;
    write_line(24'h000345, 3, ok, early);
    checks++; if (!ok) begin errors++; $display("FAIL gap_handshake got 0 exp 1"); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL gap_early_do_write got %b exp 0", early); end
    checks++; if (m_pulses != int'(LW)) begin errors++; $display("FAIL gap_pulses got %0d exp %0d", m_pulses, LW); end
    checks++;
    if (m_last_pulse_cyc - m_first_pulse_cyc != int'(LW) - 1) begin
      errors++; $display("FAIL gap_burst_span got %0d exp %0d", m_last_pulse_cyc - m_first_pulse_cyc, LW - 1);
    end
    for (int k = 0; k < int'(LW); k++) begin
      checks++;
      if (mem[line_idx(24'h000340) + k] !== line_w[k]) begin
        errors++; $display("FAIL gap_mem[%0d] got %h exp %h", k, mem[line_idx(24'h000340) + k], line_w[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, early, rr;
    int got;
    int viol0 = m_start_viol;
    idle_hold_cfg = 5;
    for (int k = 0; k < int'(LW); k++) line_w[k] = $urandom;
    write_line(24'h000400, 1, ok1, early);
    read_line(24'h000400, 0, ok2, got, rr);
    idle_hold_cfg = 1;
    checks++; if (!(ok1 && ok2) || got != int'(LW)) begin errors++; $display("FAIL b2b_handshake got %0d exp %0d", got, LW); end
    checks++; if (m_start_viol != viol0) begin errors++; $display("FAIL b2b_start_while_busy got %0d exp %0d", m_start_viol, viol0); end
    for (int k = 0; k < int'(LW); k++) begin
      checks++;
      if (rd_got[k] !== ref_mem[line_idx(24'h000400) + k]) begin
        errors++; $display("FAIL b2b_word[%0d] got %h exp %h", k, rd_got[k], ref_mem[line_idx(24'h000400) + k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, rr, hit;
    int got;
    hit = 1'b0;
    send_req(1'b0, 24'h000200, ok);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (m_busy != 0 && m_pulses >= 3) begin hit = 1'b1; break; end
    end
    checks++; if (!ok || !hit) begin errors++; $display("FAIL rstmid_reach got %b%b exp 11", ok, hit); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b exp 1", req_ready); end
    checks++; if (q_do_read !== 1'b0) begin errors++; $display("FAIL rstmid_do_read got %b exp 0", q_do_read); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid got %b exp 0", rd_valid); end
    read_line(24'h000200, 0, ok, got, rr);
    checks++; if (!ok || got != int'(LW)) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", got, LW); end
    for (int k = 0; k < int'(LW); k++) begin
      checks++;
      if (rd_got[k] !== ref_mem[line_idx(24'h000200) + k]) begin
        errors++; $display("FAIL rstmid_word[%0d] got %h exp %h", k, rd_got[k], ref_mem[line_idx(24'h000200) + k]);
      end
    end
  endtask

  task automatic test_random();
    bit ok, early, rr, bad;
    int got, bad_k;
    logic [AW-1:0] a;
    for (int t = 0; t < 12; t++) begin
      a = AW'($urandom);
      pulse_gap_cfg = int'($urandom_range(0, 2));
      idle_hold_cfg = int'($urandom_range(1, 4));
      bad = 1'b0;
      bad_k = 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'(LW); k++) line_w[k] = $urandom;
        write_line(a, int'($urandom_range(1, 3)), ok, early);
        for (int k = int'(LW) - 1; k >= 0; k--)
          if (mem[line_idx(a) + k] !== ref_mem[line_idx(a) + k]) begin bad = 1'b1; bad_k = k; end
        checks++;
        if (!ok || early || bad) begin
          errors++; $display("FAIL rand_wr[%0d] addr %h word %0d got %h exp %h", t, a, bad_k, mem[line_idx(a) + bad_k], ref_mem[line_idx(a) + bad_k]);
        end
      end else begin
        read_line(a, 2, ok, got, rr);
        for (int k = int'(LW) - 1; k >= 0; k--)
          if (rd_got[k] !== ref_mem[line_idx(a) + k]) begin bad = 1'b1; bad_k = k; end
        checks++;
        if (!ok || got != int'(LW) || bad) begin
          errors++; $display("FAIL rand_rd[%0d] addr %h count %0d word %0d got %h exp %h", t, a, got, bad_k, rd_got[bad_k], ref_mem[line_idx(a) + bad_k]);
        end
      end
    end
    pulse_gap_cfg = 0;
    idle_hold_cfg = 1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_toggle();
    test_write_gaps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
